// File: rtl/sprite_blitter.sv
// sprite_blitter: draws an 8-pixel-wide, n-row sprite into a 32-bit-per-pixel
// VRAM. Lit sprite pixels are XORed onto the screen. Every drawn pixel is a
// read-modify-write, and any erased pixel raises collision_out. Pixels past
// the right edge are clipped. Rows past the bottom edge end the draw early.
module sprite_blitter #(
  parameter int          SCREEN_W = 64,
  parameter int          SCREEN_H = 32,
  parameter logic [31:0] PIXEL_ON = 32'hFFFF_FFFF
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start_in,
  input  logic [7:0]  x_in,
  input  logic [7:0]  y_in,
  input  logic [3:0]  n_in,
  input  logic [11:0] addr_in,
  output logic [11:0] mem_addr_out,
  output logic        mem_rd_out,
  input  logic [7:0]  mem_data_in,
  output logic [10:0] vram_addr_out,
  output logic        vram_rd_out,
  input  logic [31:0] vram_rdata_in,
  output logic        vram_we_out,
  output logic [31:0] vram_wdata_out,
  output logic        busy_out,
  output logic        done_out,
  output logic        collision_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_FWAIT,
    S_PIXEL,
    S_PWAIT,
    S_PWRITE,
    S_DONE
  } state_t;

  state_t      state_reg;
  logic [7:0]  x0_reg;
  logic [7:0]  y0_reg;
  logic [3:0]  n_reg;
  logic [11:0] base_reg;
  logic [3:0]  row_reg;
  logic [2:0]  col_reg;
  logic [7:0]  row_byte_reg;

  // Per-column masks, indexed by column (column 0 = sprite MSB = leftmost).
  logic [7:0]  in_range_mask;
  logic [7:0]  fetched_mask;
  logic [7:0]  held_mask;

  logic [2:0]  col_next;
  logic [4:0]  row_inc;
  logic        row_last;
  logic        advance;
  logic [10:0] row_base;
  logic [10:0] addr_step;

  // Strobes and addresses are registered outputs. The FSM therefore decides
  // one state ahead whether the next column is drawn. The fetched-byte mask
  // is used when leaving FWAIT, and the held-byte mask when stepping columns.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_col
      assign in_range_mask[gi] = ({1'b0, x0_reg} + 9'(gi)) < 9'(SCREEN_W);
      assign fetched_mask[gi]  = mem_data_in[7-gi] & in_range_mask[gi];
      assign held_mask[gi]     = row_byte_reg[7-gi] & in_range_mask[gi];
    end
  endgenerate

  assign col_next  = col_reg + 3'd1;
  assign row_inc   = {1'b0, row_reg} + 5'd1;
  assign row_last  = (row_inc == {1'b0, n_reg}) ||
                     ((9'(y0_reg) + 9'(row_inc)) >= 9'(SCREEN_H));
  // A column is finished either by a one-cycle skip in PIXEL or by its write.
  assign advance   = ((state_reg == S_PIXEL) && !vram_rd_out) ||
                     (state_reg == S_PWRITE);
  // The current row is always on screen, so the 11-bit product cannot alias.
  assign row_base  = (11'(y0_reg) + 11'(row_reg)) * 11'(SCREEN_W) + 11'(x0_reg);
  assign addr_step = row_base + 11'(col_next);

  // Drawing FSM: this block also produces all registered outputs.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_reg      <= S_IDLE;
      x0_reg         <= 8'd0;
      y0_reg         <= 8'd0;
      n_reg          <= 4'd0;
      base_reg       <= 12'd0;
      row_reg        <= 4'd0;
      col_reg        <= 3'd0;
      row_byte_reg   <= 8'd0;
      mem_addr_out   <= 12'd0;
      mem_rd_out     <= 1'b0;
      vram_addr_out  <= 11'd0;
      vram_rd_out    <= 1'b0;
      vram_we_out    <= 1'b0;
      vram_wdata_out <= 32'd0;
      busy_out       <= 1'b0;
      done_out       <= 1'b0;
      collision_out  <= 1'b0;
    end else begin
      mem_rd_out  <= 1'b0;
      vram_rd_out <= 1'b0;
      vram_we_out <= 1'b0;
      done_out    <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          if (start_in) begin
            x0_reg        <= 8'(x_in % SCREEN_W);
            y0_reg        <= 8'(y_in % SCREEN_H);
            n_reg         <= n_in;
            base_reg      <= addr_in;
            row_reg       <= 4'd0;
            col_reg       <= 3'd0;
            collision_out <= 1'b0;
            busy_out      <= 1'b1;
            if (n_in == 4'd0) begin
              state_reg <= S_DONE;
              done_out  <= 1'b1;
            end else begin
              state_reg    <= S_FETCH;
              mem_rd_out   <= 1'b1;
              mem_addr_out <= addr_in;
            end
          end
        end

        S_FETCH: begin
          state_reg <= S_FWAIT;
        end

        S_FWAIT: begin
          row_byte_reg  <= mem_data_in;
          col_reg       <= 3'd0;
          state_reg     <= S_PIXEL;
          vram_rd_out   <= fetched_mask[0];
          vram_addr_out <= row_base;
        end

        S_PIXEL: begin
          if (vram_rd_out) begin
            state_reg <= S_PWAIT;
          end
        end

        S_PWAIT: begin
          state_reg   <= S_PWRITE;
          vram_we_out <= 1'b1;
          if (vram_rdata_in != 32'd0) begin
            vram_wdata_out <= 32'd0;
            collision_out  <= 1'b1;
          end else begin
            vram_wdata_out <= PIXEL_ON;
          end
        end

        S_PWRITE: begin
          // Column stepping is handled below, together with the PIXEL skip path.
        end

        S_DONE: begin
          state_reg <= S_IDLE;
          busy_out  <= 1'b0;
        end

        default: begin
          state_reg <= S_IDLE;
          busy_out  <= 1'b0;
        end
      endcase

      if (advance) begin
        if (col_reg != 3'd7) begin
          col_reg       <= col_next;
          state_reg     <= S_PIXEL;
          vram_rd_out   <= held_mask[col_next];
          vram_addr_out <= addr_step;
        end else begin
          row_reg <= row_inc[3:0];
          if (row_last) begin
            state_reg <= S_DONE;
            done_out  <= 1'b1;
          end else begin
            state_reg    <= S_FETCH;
            mem_rd_out   <= 1'b1;
            mem_addr_out <= base_reg + 12'(row_inc);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter: directed scenarios for sprite_blitter with behavioural
// main-memory and VRAM models. Expected values are hand-derived.
module tb_sprite_blitter;

  localparam logic [31:0] ON = 32'hFFFF_FFFF;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        start_in = 1'b0;
  logic [7:0]  x_in = 8'd0;
  logic [7:0]  y_in = 8'd0;
  logic [3:0]  n_in = 4'd0;
  logic [11:0] addr_in = 12'd0;
  logic [11:0] mem_addr_out;
  logic        mem_rd_out;
  logic [7:0]  mem_data_in = 8'd0;
  logic [10:0] vram_addr_out;
  logic        vram_rd_out;
  logic [31:0] vram_rdata_in = 32'd0;
  logic        vram_we_out;
  logic [31:0] vram_wdata_out;
  logic        busy_out;
  logic        done_out;
  logic        collision_out;

  int total = 0;
  int bad = 0;

  logic [7:0]  mem [4096];
  logic [31:0] vram [2048];
  int          rd_q [$];
  int          wa_q [$];
  logic [31:0] wd_q [$];
  int          vrd_count = 0;
  int          excl_bad = 0;
  int          long_bad = 0;
  int          done_pulses = 0;
  bit          clear_req = 1'b0;
  logic        prev_m = 1'b0;
  logic        prev_r = 1'b0;
  logic        prev_w = 1'b0;

  int exp_glyph [14] = '{0, 1, 2, 3, 64, 67, 128, 131, 192, 195, 256, 257, 258, 259};

  logic [60:0] outs;
  assign outs = {busy_out, done_out, collision_out, mem_rd_out, vram_rd_out,
                 vram_we_out, mem_addr_out, vram_addr_out, vram_wdata_out};

  sprite_blitter #(
    .SCREEN_W(64),
    .SCREEN_H(32),
    .PIXEL_ON(ON)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .start_in      (start_in),
    .x_in          (x_in),
    .y_in          (y_in),
    .n_in          (n_in),
    .addr_in       (addr_in),
    .mem_addr_out  (mem_addr_out),
    .mem_rd_out    (mem_rd_out),
    .mem_data_in   (mem_data_in),
    .vram_addr_out (vram_addr_out),
    .vram_rd_out   (vram_rd_out),
    .vram_rdata_in (vram_rdata_in),
    .vram_we_out   (vram_we_out),
    .vram_wdata_out(vram_wdata_out),
    .busy_out      (busy_out),
    .done_out      (done_out),
    .collision_out (collision_out)
  );

  always #5 clk_in = ~clk_in;

  // Memory and VRAM models with one-cycle read latency, plus bus logging.
  always @(posedge clk_in) begin
    if (clear_req) begin
      for (int i = 0; i < 2048; i++) vram[i] = 32'd0;
    end
    if (mem_rd_out) begin
      mem_data_in <= mem[mem_addr_out];
      rd_q.push_back(int'(mem_addr_out));
    end
    if (vram_rd_out) begin
      vram_rdata_in <= vram[vram_addr_out];
      vrd_count++;
    end
    if (vram_we_out) begin
      vram[vram_addr_out] = vram_wdata_out;
      wa_q.push_back(int'(vram_addr_out));
      wd_q.push_back(vram_wdata_out);
    end
    if ((int'(mem_rd_out) + int'(vram_rd_out) + int'(vram_we_out)) > 1) excl_bad++;
    if ((mem_rd_out && prev_m) || (vram_rd_out && prev_r) || (vram_we_out && prev_w)) long_bad++;
    prev_m = mem_rd_out;
    prev_r = vram_rd_out;
    prev_w = vram_we_out;
    if (done_out) done_pulses++;
  end

  task automatic clear_vram();
    @(negedge clk_in);
    clear_req = 1'b1;
    @(posedge clk_in);
    #1;
    clear_req = 1'b0;
  endtask

  // Present a request; returns at 1 time unit after the accepting edge.
  task automatic start_draw(input logic [7:0] x, input logic [7:0] y,
                            input logic [3:0] n, input logic [11:0] a);
    @(negedge clk_in);
    x_in = x;
    y_in = y;
    n_in = n;
    addr_in = a;
    start_in = 1'b1;
    @(posedge clk_in);
    #1;
    start_in = 1'b0;
  endtask

  // Cycle 1 is the cycle right after the accepting edge. Returns limit+1 on timeout.
  task automatic wait_done(input int limit, output int cyc);
    cyc = 1;
    while (cyc <= limit) begin
      if (done_out === 1'b1) break;
      @(posedge clk_in);
      #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    int rb;
    int vb;
    rst_in = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    total++;
    if (outs !== 61'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0", outs);
    end
    rb = rd_q.size();
    vb = vrd_count;
    // Release and request together: the first rising edge must accept (n=0).
    @(negedge clk_in);
    rst_in = 1'b1;
    x_in = 8'd5;
    y_in = 8'd5;
    n_in = 4'd0;
    addr_in = 12'h123;
    start_in = 1'b1;
    @(posedge clk_in);
    #1;
    start_in = 1'b0;
    total++;
    if ({busy_out, done_out} !== 2'b11) begin
      bad++;
      $display("FAIL n0_done_at_1: busy/done got %b want 11", {busy_out, done_out});
    end
    @(posedge clk_in);
    #1;
    total++;
    if ({busy_out, done_out} !== 2'b00) begin
      bad++;
      $display("FAIL n0_idle_after: busy/done got %b want 00", {busy_out, done_out});
    end
    total++;
    if ((rd_q.size() - rb) !== 0 || (vrd_count - vb) !== 0 || wa_q.size() !== 0) begin
      bad++;
      $display("FAIL n0_no_access: mem reads %0d vram reads %0d writes %0d want 0",
               rd_q.size() - rb, vrd_count - vb, wa_q.size());
    end
    $display("reset and n=0 draw complete");
  endtask

  task automatic test_glyph(input bit collide);
    int rb;
    int wb;
    int cyc;
    int got;
    logic [31:0] want;
    if (!collide) clear_vram();
    rb = rd_q.size();
    wb = wa_q.size();
    start_draw(8'd0, 8'd0, 4'd5, 12'h000);
    wait_done(200, cyc);
    $display("glyph draw collide=%0d done after %0d cycles", collide, cyc);
    total++;
    if (cyc !== 79) begin
      bad++;
      $display("FAIL glyph_cycles: got %0d want 79", cyc);
    end
    total++;
    if (collision_out !== collide) begin
      bad++;
      $display("FAIL glyph_collision: got %b want %b", collision_out, collide);
    end
    total++;
    if (busy_out !== 1'b1) begin
      bad++;
      $display("FAIL glyph_busy_in_done: got %b want 1", busy_out);
    end
    got = wa_q.size() - wb;
    total++;
    if (got !== 14) begin
      bad++;
      $display("FAIL glyph_write_count: got %0d want 14", got);
    end
    want = collide ? 32'd0 : ON;
    for (int i = 0; i < 14 && i < got; i++) begin
      total++;
      if (wa_q[wb+i] !== exp_glyph[i] || wd_q[wb+i] !== want) begin
        bad++;
        $display("FAIL glyph_write%0d: got @%0d=%h want @%0d=%h",
                 i, wa_q[wb+i], wd_q[wb+i], exp_glyph[i], want);
      end
    end
    total++;
    if ((rd_q.size() - rb) !== 5) begin
      bad++;
      $display("FAIL glyph_read_count: got %0d want 5", rd_q.size() - rb);
    end else begin
      for (int i = 0; i < 5; i++) begin
        total++;
        if (rd_q[rb+i] !== i) begin
          bad++;
          $display("FAIL glyph_read%0d: got %h want %h", i, rd_q[rb+i], i);
        end
      end
    end
    @(posedge clk_in);
    #1;
    total++;
    if ({busy_out, done_out, collision_out} !== {2'b00, collide}) begin
      bad++;
      $display("FAIL glyph_after_done: busy/done/coll got %b want %b",
               {busy_out, done_out, collision_out}, {2'b00, collide});
    end
  endtask

  // Single-row draws: checks cycle count, every write address and the reads.
  task automatic test_single(input string name, input logic [7:0] x, input logic [7:0] y,
                             input logic [3:0] n, input logic [11:0] a,
                             input int exp_cyc, input int exp_w0, input int exp_nw,
                             input int exp_r0, input int exp_nr);
    int rb;
    int wb;
    int cyc;
    clear_vram();
    rb = rd_q.size();
    wb = wa_q.size();
    start_draw(x, y, n, a);
    wait_done(200, cyc);
    $display("%s draw x=%0d y=%0d n=%0d addr=%h done after %0d cycles", name, x, y, n, a, cyc);
    total++;
    if (cyc !== exp_cyc) begin
      bad++;
      $display("FAIL %s_cycles: got %0d want %0d", name, cyc, exp_cyc);
    end
    total++;
    if ((wa_q.size() - wb) !== exp_nw) begin
      bad++;
      $display("FAIL %s_write_count: got %0d want %0d", name, wa_q.size() - wb, exp_nw);
    end else begin
      for (int i = 0; i < exp_nw; i++) begin
        total++;
        if (wa_q[wb+i] !== exp_w0 + i || wd_q[wb+i] !== ON) begin
          bad++;
          $display("FAIL %s_write%0d: got @%0d=%h want @%0d=%h",
                   name, i, wa_q[wb+i], wd_q[wb+i], exp_w0 + i, ON);
        end
      end
    end
    total++;
    if ((rd_q.size() - rb) !== exp_nr) begin
      bad++;
      $display("FAIL %s_read_count: got %0d want %0d", name, rd_q.size() - rb, exp_nr);
    end else begin
      for (int i = 0; i < exp_nr; i++) begin
        total++;
        if (rd_q[rb+i] !== ((exp_r0 + i) % 4096)) begin
          bad++;
          $display("FAIL %s_read%0d: got %h want %h", name, i, rd_q[rb+i], (exp_r0 + i) % 4096);
        end
      end
    end
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset_mid();
    int wb;
    int cyc;
    int dp;
    clear_vram();
    wb = wa_q.size();
    start_draw(8'd0, 8'd0, 4'd5, 12'h000);
    repeat (34) @(posedge clk_in);
    #1;
    // Cycle 35: PIXEL column 0 of row 2 issues its VRAM read.
    total++;
    if ({vram_rd_out, vram_addr_out} !== {1'b1, 11'd128}) begin
      bad++;
      $display("FAIL mid_row2_read: got rd=%b addr=%0d want rd=1 addr=128",
               vram_rd_out, vram_addr_out);
    end
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    #1;
    total++;
    if (outs !== 61'd0) begin
      bad++;
      $display("FAIL mid_reset_outputs: got %h want 0", outs);
    end
    repeat (3) @(posedge clk_in);
    #1;
    total++;
    if ((wa_q.size() - wb) !== 6 || outs !== 61'd0) begin
      bad++;
      $display("FAIL mid_reset_hold: writes %0d outs %h want 6 and 0", wa_q.size() - wb, outs);
    end
    $display("reset applied mid-draw after %0d writes", wa_q.size() - wb);
    @(negedge clk_in);
    rst_in = 1'b1;
    wb = wa_q.size();
    start_draw(8'd0, 8'd0, 4'd5, 12'h000);
    cyc = 1;
    while (cyc <= 200) begin
      if (done_out === 1'b1) break;
      if (cyc == 10) start_in = 1'b1;
      if (cyc == 11) start_in = 1'b0;
      @(posedge clk_in);
      #1;
      cyc++;
    end
    $display("redraw after reset done after %0d cycles", cyc);
    total++;
    if (cyc !== 79 || collision_out !== 1'b1) begin
      bad++;
      $display("FAIL redraw_done: cycles %0d coll %b want 79 and 1", cyc, collision_out);
    end
    total++;
    if ((wa_q.size() - wb) !== 14) begin
      bad++;
      $display("FAIL redraw_write_count: got %0d want 14", wa_q.size() - wb);
    end else begin
      for (int i = 0; i < 14; i++) begin
        total++;
        if (wa_q[wb+i] !== exp_glyph[i] || wd_q[wb+i] !== ((i < 6) ? 32'd0 : ON)) begin
          bad++;
          $display("FAIL redraw_write%0d: got @%0d=%h want @%0d=%h", i, wa_q[wb+i],
                   wd_q[wb+i], exp_glyph[i], (i < 6) ? 32'd0 : ON);
        end
      end
    end
    @(posedge clk_in);
    #1;
    dp = done_pulses;
    repeat (100) @(posedge clk_in);
    #1;
    total++;
    if ((done_pulses - dp) !== 0 || busy_out !== 1'b0) begin
      bad++;
      $display("FAIL no_queued_start: extra done %0d busy %b want 0 and 0",
               done_pulses - dp, busy_out);
    end
  endtask

  task automatic test_strobes();
    total++;
    if (excl_bad !== 0 || long_bad !== 0) begin
      bad++;
      $display("FAIL strobe_rules: overlap %0d stretched %0d want 0 and 0", excl_bad, long_bad);
    end
    $display("strobe exclusivity and width checked");
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[0] = 8'hF0;
    mem[1] = 8'h90;
    mem[2] = 8'h90;
    mem[3] = 8'h90;
    mem[4] = 8'hF0;
    mem[12'h010] = 8'hFF;
    mem[12'h011] = 8'h80;
    mem[12'h020] = 8'h80;
    mem[12'h021] = 8'h80;
    mem[12'h022] = 8'h80;
    mem[12'hFFF] = 8'h00;

    test_reset();
    test_glyph(1'b0);
    test_glyph(1'b1);
    test_single("clip_x", 8'd62, 8'd0, 4'd1, 12'h010, 15, 62, 2, 12'h010, 1);
    test_single("origin_mod", 8'd70, 8'd33, 4'd1, 12'h011, 13, 70, 1, 12'h011, 1);
    test_single("clip_y", 8'd0, 8'd31, 4'd3, 12'h020, 13, 1984, 1, 12'h020, 1);
    test_single("addr_wrap", 8'd8, 8'd10, 4'd2, 12'hFFF, 29, 712, 4, 12'hFFF, 2);
    test_reset_mid();
    test_strobes();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
